// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue: fetch PC owner, single-outstanding I-cache reader and circular |
// | queue of predicted instructions feeding decode.               Rev 1.0       |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic [31:0]                 btb_lookup_pc,
  input  logic                        btb_hit,
  input  logic [31:0]                 btb_target,
  output logic                        imem_read,
  output logic [31:0]                 imem_address,
  input  logic                        imem_resp,
  input  logic [31:0]                 imem_rdata,
  output logic                        deq_valid,
  input  logic                        deq_ready,
  output logic [31:0]                 deq_pc,
  output logic [31:0]                 deq_instr,
  output logic                        deq_pred_taken,
  output logic [31:0]                 deq_pred_pc,
  output logic [31:0]                 deq_pc_next,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int c_PW = $clog2(FQ_DEPTH);
  localparam int c_CW = c_PW + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FQ_DEPTH);
  localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);

  logic [1:0]       r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic             r_req_pred_taken;
  logic [31:0]      r_req_pred_pc;
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_CW-1:0]  r_count;

  logic [31:0]      r_q_pc     [FQ_DEPTH];
  logic [31:0]      r_q_instr  [FQ_DEPTH];
  logic             r_q_taken  [FQ_DEPTH];
  logic [31:0]      r_q_ppc    [FQ_DEPTH];

  logic             w_deq_valid;
  logic             w_enq;
  logic             w_deq;
  logic [c_CW-1:0]  w_count_next;
  logic             w_can_issue;
  logic             w_issue;
  logic [1:0]       w_state_next;

  assign w_deq_valid  = (r_count != '0);
  assign w_deq        = w_deq_valid & deq_ready;
  // Stale responses (DRAIN) and responses racing a redirect are never enqueued.
  assign w_enq        = (r_state == c_WAIT) & imem_resp & ~redirect_valid;
  assign w_count_next = r_count + {{(c_CW-1){1'b0}}, w_enq} - {{(c_CW-1){1'b0}}, w_deq};
  assign w_can_issue  = (w_count_next < c_DEPTH);

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (!redirect_valid && w_can_issue) begin
          w_issue      = 1'b1;
          w_state_next = c_WAIT;
        end
      end
      c_WAIT: begin
        if (redirect_valid) begin
          w_state_next = imem_resp ? c_IDLE : c_DRAIN;
        end else if (imem_resp) begin
          if (w_can_issue) begin
            w_issue      = 1'b1;
            w_state_next = c_WAIT;
          end else begin
            w_state_next = c_IDLE;
          end
        end
      end
      c_DRAIN: begin
        if (imem_resp) w_state_next = c_IDLE;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= c_IDLE;
      r_fetch_pc       <= RESET_PC;
      r_req_pc         <= RESET_PC;
      r_req_pred_taken <= 1'b0;
      r_req_pred_pc    <= '0;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= btb_hit ? btb_target : r_fetch_pc + 32'd4;
      end
      if (w_issue) begin
        r_req_pc         <= r_fetch_pc;
        r_req_pred_taken <= btb_hit;
        r_req_pred_pc    <= btb_hit ? btb_target : 32'd0;
      end
      if (redirect_valid) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + c_PTR_ONE;
        if (w_deq) r_head <= r_head + c_PTR_ONE;
        r_count <= w_count_next;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (rst && w_enq) begin
      r_q_pc[r_tail]    <= r_req_pc;
      r_q_instr[r_tail] <= imem_rdata;
      r_q_taken[r_tail] <= r_req_pred_taken;
      r_q_ppc[r_tail]   <= r_req_pred_pc;
    end
  end

  assign btb_lookup_pc  = r_fetch_pc;
  assign imem_read      = (r_state == c_WAIT) || (r_state == c_DRAIN);
  assign imem_address   = r_req_pc;
  assign deq_valid      = w_deq_valid;
  assign deq_pc         = r_q_pc[r_head];
  assign deq_instr      = r_q_instr[r_head];
  assign deq_pred_taken = r_q_taken[r_head];
  assign deq_pred_pc    = r_q_ppc[r_head];
  assign deq_pc_next    = r_q_taken[r_head] ? r_q_ppc[r_head] : r_q_pc[r_head] + 32'd4;
  assign fq_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue: directed scenarios against fetch_queue with a simple        |
// | latency-programmable I-cache and single-entry BTB.            Rev 1.0       |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam logic [31:0] c_RST  = 32'h4000_0000;
  localparam logic [31:0] c_XOR  = 32'hDEAD_0000;
  localparam logic [31:0] c_REDIR = 32'h4000_0200;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] btb_lookup_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_pred_taken;
  logic [31:0] deq_pred_pc;
  logic [31:0] deq_pc_next;
  logic [2:0]  fq_count;

  int checks   = 0;
  int failures = 0;

  logic        btb_en;
  logic [31:0] btb_src;
  logic [31:0] btb_dst;
  int          lat;
  int          ccnt = 0;

  fetch_queue #(.RESET_PC(c_RST), .FQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_lookup_pc(btb_lookup_pc), .btb_hit(btb_hit), .btb_target(btb_target),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr), .deq_pred_taken(deq_pred_taken),
    .deq_pred_pc(deq_pred_pc), .deq_pc_next(deq_pc_next), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign btb_hit    = btb_en && (btb_lookup_pc == btb_src);
  assign btb_target = btb_dst;

  // Cache answers once a read has been held for lat+1 cycles.
  always @(posedge clk) begin
    #1;
    if (imem_read === 1'b1) begin
      if (ccnt >= lat) begin
        imem_resp  = 1'b1;
        imem_rdata = imem_address ^ c_XOR;
        ccnt       = 0;
      end else begin
        imem_resp = 1'b0;
        ccnt      = ccnt + 1;
      end
    end else begin
      imem_resp = 1'b0;
      ccnt      = 0;
    end
  end

  task automatic do_reset;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    deq_ready = 1'b0; btb_en = 1'b0; btb_src = 32'd0; btb_dst = 32'd0; lat = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", imem_read); end
    checks++; if (imem_address !== c_RST) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_address, c_RST); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", deq_valid); end
    checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fq_count); end
    checks++; if (btb_lookup_pc !== c_RST) begin failures++; $display("FAIL reset_lookup got=%h exp=%h", btb_lookup_pc, c_RST); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL first_read got=%b exp=1", imem_read); end
    checks++; if (imem_address !== c_RST) begin failures++; $display("FAIL first_addr got=%h exp=%h", imem_address, c_RST); end
  endtask

  task automatic test_stream;
    logic [31:0] pc;
    do_reset();
    deq_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL stream_fill_latency got=%b exp=0", deq_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pc = c_RST + 32'(4 * i);
      checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, deq_valid); end
      checks++; if (deq_pc !== pc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, deq_pc, pc); end
      checks++; if (deq_instr !== (pc ^ c_XOR)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, deq_instr, pc ^ c_XOR); end
      checks++; if (deq_pc_next !== pc + 32'd4) begin failures++; $display("FAIL stream_next[%0d] got=%h exp=%h", i, deq_pc_next, pc + 32'd4); end
      checks++; if (deq_pred_taken !== 1'b0) begin failures++; $display("FAIL stream_taken[%0d] got=%b exp=0", i, deq_pred_taken); end
    end
  endtask

  task automatic test_btb;
    logic [31:0] e_pc  [6];
    logic        e_tk  [6];
    logic [31:0] e_ppc [6];
    logic [31:0] e_nx  [6];
    e_pc  = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_0100, 32'h4000_0104, 32'h4000_0108};
    e_tk  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e_ppc = '{32'd0, 32'd0, 32'h4000_0100, 32'd0, 32'd0, 32'd0};
    e_nx  = '{32'h4000_0004, 32'h4000_0008, 32'h4000_0100, 32'h4000_0104, 32'h4000_0108, 32'h4000_010C};
    do_reset();
    btb_en = 1'b1; btb_src = 32'h4000_0008; btb_dst = 32'h4000_0100;
    deq_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (deq_pc !== e_pc[i]) begin failures++; $display("FAIL btb_pc[%0d] got=%h exp=%h", i, deq_pc, e_pc[i]); end
      checks++; if (deq_pred_taken !== e_tk[i]) begin failures++; $display("FAIL btb_taken[%0d] got=%b exp=%b", i, deq_pred_taken, e_tk[i]); end
      checks++; if (deq_pred_pc !== e_ppc[i]) begin failures++; $display("FAIL btb_pred_pc[%0d] got=%h exp=%h", i, deq_pred_pc, e_ppc[i]); end
      checks++; if (deq_pc_next !== e_nx[i]) begin failures++; $display("FAIL btb_next[%0d] got=%h exp=%h", i, deq_pc_next, e_nx[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pc;
    int peak;
    do_reset();
    rst = 1'b1; peak = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(fq_count) > peak) peak = int'(fq_count);
    end
    checks++; if (peak !== 4) begin failures++; $display("FAIL bp_peak got=%0d exp=4", peak); end
    checks++; if (fq_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", fq_count); end
    checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL bp_read got=%b exp=0", imem_read); end
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc = c_RST + 32'(4 * i);
      checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, deq_valid); end
      checks++; if (deq_pc !== pc) begin failures++; $display("FAIL bp_pc[%0d] got=%h exp=%h", i, deq_pc, pc); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_drain;
    logic [31:0] e_addr [5];
    logic        e_rd   [5];
    int waited;
    e_addr = '{32'h4000_0008, 32'h4000_0008, 32'h4000_0008, 32'h4000_0008, c_REDIR};
    e_rd   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lat = 3;
    @(negedge clk);
    checks++; if (fq_count !== 3'd2) begin failures++; $display("FAIL drain_pre_count got=%0d exp=2", fq_count); end
    redirect_valid = 1'b1; redirect_pc = c_REDIR;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL drain_flush_count got=%0d exp=0", fq_count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL drain_flush_valid got=%b exp=0", deq_valid); end
    checks++; if (btb_lookup_pc !== c_REDIR) begin failures++; $display("FAIL drain_fetch_pc got=%h exp=%h", btb_lookup_pc, c_REDIR); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_read !== e_rd[i]) begin failures++; $display("FAIL drain_read[%0d] got=%b exp=%b", i, imem_read, e_rd[i]); end
      if (e_rd[i]) begin
        checks++; if (imem_address !== e_addr[i]) begin failures++; $display("FAIL drain_addr[%0d] got=%h exp=%h", i, imem_address, e_addr[i]); end
      end
      checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL drain_stale_valid[%0d] got=%b exp=0", i, deq_valid); end
      if (i < 4) @(negedge clk);
    end
    deq_ready = 1'b1;
    waited = 0;
    while (deq_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", deq_valid); end
    checks++; if (deq_pc !== c_REDIR) begin failures++; $display("FAIL drain_first_pc got=%h exp=%h", deq_pc, c_REDIR); end
    checks++; if (deq_instr !== (c_REDIR ^ c_XOR)) begin failures++; $display("FAIL drain_first_instr got=%h exp=%h", deq_instr, c_REDIR ^ c_XOR); end
  endtask

  task automatic test_redirect_resp;
    do_reset();
    deq_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (deq_valid !== 1'b1) begin failures++; $display("FAIL rr_pre_valid got=%b exp=1", deq_valid); end
    checks++; if (imem_address !== 32'h4000_0004) begin failures++; $display("FAIL rr_pre_addr got=%h exp=40000004", imem_address); end
    redirect_valid = 1'b1; redirect_pc = c_REDIR;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL rr_count got=%0d exp=0", fq_count); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rr_valid got=%b exp=0", deq_valid); end
    checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL rr_read got=%b exp=0", imem_read); end
    @(negedge clk);
    checks++; if (imem_address !== c_REDIR) begin failures++; $display("FAIL rr_addr got=%h exp=%h", imem_address, c_REDIR); end
    checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL rr_read2 got=%b exp=1", imem_read); end
    @(negedge clk);
    checks++; if (deq_pc !== c_REDIR) begin failures++; $display("FAIL rr_deq_pc got=%h exp=%h", deq_pc, c_REDIR); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fq_count !== 3'd2) begin failures++; $display("FAIL rm_pre_count got=%0d exp=2", fq_count); end
    checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL rm_pre_read got=%b exp=1", imem_read); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_read !== 1'b0) begin failures++; $display("FAIL rm_read got=%b exp=0", imem_read); end
    checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", deq_valid); end
    checks++; if (imem_address !== c_RST) begin failures++; $display("FAIL rm_addr got=%h exp=%h", imem_address, c_RST); end
    checks++; if (fq_count !== 3'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", fq_count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_read !== 1'b1) begin failures++; $display("FAIL rm_restart_read got=%b exp=1", imem_read); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_btb();
    test_backpressure();
    test_redirect_drain();
    test_redirect_resp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Decoupled, parametrised instruction-fetch stage with a circular fetch queue between the I-cache and decode. It owns the architectural fetch PC and issues one I-cache read at a time under the cache's hold-until-resp protocol. It captures the BTB prediction at issue and buffers up to FQ_DEPTH fetched instructions, so decode stalls no longer stall the I-cache. An EX-stage redirect flushes the queue and discards any in-flight stale response.

## Interface
Parameters:
- RESET_PC, 32'h4000_0000, fetch PC after reset
- FQ_DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- redirect_valid  in  1  EX mispredict; flush and refetch
- redirect_pc  in  32  corrected PC
- btb_lookup_pc  out  32  equals fetch_pc
- btb_hit  in  1  combinational hit for btb_lookup_pc
- btb_target  in  32  predicted target
- imem_read  out  1  I-cache read request
- imem_address  out  32  request address; stable while imem_read=1
- imem_resp  in  1  read complete this cycle
- imem_rdata  in  32  instruction, valid with imem_resp
- deq_valid  out  1  head entry valid
- deq_ready  in  1  decode consumes head
- deq_pc  out  32  head PC
- deq_instr  out  32  head instruction
- deq_pred_taken  out  1  prediction captured at issue
- deq_pred_pc  out  32  btb target if taken, else 0
- deq_pc_next  out  32  pred_taken ? pred_pc : pc+4
- fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc, req_pc, req_pred_taken, req_pred_pc, state, head/tail pointers ($clog2(FQ_DEPTH) bits, wrap modulo FQ_DEPTH), count.
- States: IDLE (no request), WAIT (request outstanding), DRAIN (outstanding request is stale).
- imem_read = 1 in WAIT and DRAIN; imem_address = req_pc.
- can_issue = count_next < FQ_DEPTH, where count_next is count after this cycle's enqueue/dequeue. One outstanding request guarantees it never overflows.
- Issue (IDLE→WAIT, or WAIT→WAIT on resp): req_pc←fetch_pc, req_pred_taken←btb_hit, req_pred_pc←btb_hit ? btb_target : 0, fetch_pc←btb_hit ? btb_target : fetch_pc+4 (32-bit wrap).
- IDLE: redirect_valid → fetch_pc←redirect_pc, stay IDLE. Else can_issue → issue.
- WAIT, imem_resp=1, no redirect: enqueue {req_pc, imem_rdata, req_pred_*} at tail. can_issue → issue (back-to-back), else IDLE.
- WAIT, imem_resp=1, redirect: drop response, fetch_pc←redirect_pc, IDLE.
- WAIT, imem_resp=0, redirect: fetch_pc←redirect_pc, DRAIN (address must stay stable).
- DRAIN: imem_resp → discard, IDLE. Redirect in DRAIN updates fetch_pc again and stays DRAIN.
- Dequeue when deq_valid & deq_ready: head advances.
- Redirect priority: over enqueue, dequeue and issue. Head, tail and count clear that edge; deq_valid=0 next cycle.
- deq_valid = (count≠0). deq_* fields are driven from the head entry. With empty queue the deq_* fields are don't-care, but deq_valid=0.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal when full only if a dequeue occurs; it is not reachable with enqueue-on-full by construction.

## Timing
- Reset (rst=0 at edge): state IDLE, fetch_pc=req_pc=RESET_PC, imem_read=0, imem_address=RESET_PC, deq_valid=0, fq_count=0, pointers 0, pred regs 0. Reset mid-request abandons it; the cache must tolerate read deasserting.
- First edge with rst=1: IDLE→WAIT. imem_read=1, imem_address=RESET_PC in the following cycle.
- Entry enqueued at the edge sampling imem_resp. deq_valid=1 from the next cycle (1-cycle fill latency, no bypass).
- With a single-cycle-hit cache and deq_ready=1: one instruction per cycle sustained after the first.
- Redirect at edge N: the first new request is issued at edge N+1 from IDLE. From DRAIN, it is issued at the edge after the stale resp.

## Test plan
- Reset then free-run, cache resp 1 cycle after each read, deq_ready=1, no BTB hits → deq_pc sequence 0x40000000, 0x40000004, 0x40000008… on consecutive cycles; deq_pc_next = pc+4.
- BTB hit at 0x40000008 with target 0x40000100 → entry 0x40000008 has pred_taken=1, pred_pc=0x40000100, and the next deq_pc is 0x40000100.
- deq_ready=0 for 10 cycles (FQ_DEPTH=4) → fq_count saturates at 4, imem_read drops to 0. Raising deq_ready resumes fetch with no lost or duplicated PC.
- Redirect to 0x40000200 while WAIT and imem_resp delayed 3 cycles → imem_address held through DRAIN, stale instruction never dequeued, next request address 0x40000200, queue empty the cycle after the redirect.
- Redirect in the same cycle as imem_resp and a dequeue → response dropped, fq_count=0 next cycle, next fetch 0x40000200.
- rst=0 asserted while WAIT with 2 queued entries → next cycle imem_read=0, deq_valid=0, imem_address=0x40000000.
